// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// The segment table is active-low {g,f,e,d,c,b,a}, indexed by the hex nibble.
package seg_pkg;

  localparam int NUM_DIGITS          = 8;
  localparam int IDX_W               = $clog2(NUM_DIGITS);
  localparam int REFRESH_DIV_DEFAULT = 100000;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;

  // Entry 15 first so that HEX_SEG[n] selects the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [31:0]           value;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] en;
  } disp_cfg_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit time-multiplexed seven-segment scanner with double-buffered
// display contents that only change at a frame boundary.
module seg_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_mask,
  input  logic        load,
  output logic [7:0]  Anode,
  output logic [7:0]  Cathode,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  disp_cfg_t        pend_q, pend_d, act_q, act_d, load_cfg;
  logic [7:0]       anode_q, anode_d, cathode_q, cathode_d;
  logic             frame_done_q, frame_done_d;
  logic             tick, wrap;
  logic [6:0]       seg;

  hex_to_7seg u_hex (
    .nibble (act_q.value[{idx_q, 2'b00} +: 4]),
    .seg    (seg)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tick         = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    wrap         = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 1'b1 : idx_q;
    frame_done_d = wrap;

    load_cfg = '{value: value, dp: dp_in, en: en_mask};
    pend_d   = load ? load_cfg : pend_q;
    // A load landing on the wrap cycle bypasses pending and goes live at once.
    act_d    = wrap ? (load ? load_cfg : pend_q) : act_q;

    anode_d   = SEG_BLANK;
    cathode_d = SEG_BLANK;
    if (act_q.en[idx_q]) begin
      anode_d   = ~(8'h01 << idx_q);
      cathode_d = {~act_q.dp[idx_q], seg};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      anode_q      <= SEG_BLANK;
      cathode_q    <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Anode      = anode_q;
  assign Cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed scenarios plus random loads/resets,
// compared against a cycle-count based model of the scan.
module tb_seg_scan;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en_mask = '0;
  logic [7:0]  anode, cathode;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan #(.REFRESH_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .load       (load),
    .Anode      (anode),
    .Cathode    (cathode),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Model: n = edges since the last reset edge; the scan position follows from n.
  int          n = 0;
  logic [31:0] m_pv = '0, m_av = '0;
  logic [7:0]  m_pd = '0, m_pe = '0, m_ad = '0, m_ae = '0;
  logic [7:0]  e_an = 8'hFF, e_cat = 8'hFF;
  logic        e_fd = 1'b0;
  logic        prev_fd = 1'b0;

  function automatic logic [7:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [31:0] v,
                      input logic [7:0] dp, input logic [7:0] en);
    int d;
    rst = r; load = l; value = v; dp_in = dp; en_mask = en;
    @(posedge clk);
    if (r) begin
      n = 0;
      m_pv = '0; m_pd = '0; m_pe = '0;
      m_av = '0; m_ad = '0; m_ae = '0;
      e_an = 8'hFF; e_cat = 8'hFF; e_fd = 1'b0;
    end else begin
      d = (n / D) % 8;
      e_an = 8'hFF; e_cat = 8'hFF;
      if (m_ae[d]) begin
        e_an  = ~(8'h01 << d);
        e_cat = seg_of(m_av[4*d +: 4]);
        if (m_ad[d]) e_cat[7] = 1'b0;
      end
      n++;
      e_fd = (n % FRAME == 0);
      if (e_fd) begin
        m_av = l ? v : m_pv; m_ad = l ? dp : m_pd; m_ae = l ? en : m_pe;
      end
      if (l) begin
        m_pv = v; m_pd = dp; m_pe = en;
      end
    end
    #1;
    check("anode", anode, e_an);
    check("cathode", cathode, e_cat);
    check("frame_done", frame_done, e_fd);
    check("anode_onehot", ($countones(~anode) <= 1), 1);
    check("fd_double", prev_fd && frame_done, 0);
    prev_fd = frame_done;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  // Idle until the frame position n % FRAME equals pos (always within one frame).
  task automatic advance_to(input int pos);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) idle(1);
  endtask

  int gap;

  initial begin
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 32'h12345678, 8'hFF, 8'hFF);   // load during reset is dropped
    idle(40);

    step(1'b0, 1'b1, 32'h76543210, 8'h00, 8'hFF);
    idle(2 * FRAME);

    step(1'b0, 1'b1, 32'hFFFFFFFF, 8'h01, 8'h81);
    idle(2 * FRAME);

    advance_to(2);
    step(1'b0, 1'b1, 32'hAAAA5555, 8'hF0, 8'hFF);
    idle(5);
    step(1'b0, 1'b1, 32'h89ABCDEF, 8'h0F, 8'h7E);
    idle(FRAME + 8);

    advance_to(FRAME - 1);
    step(1'b0, 1'b1, 32'hC0FFEE42, 8'h55, 8'hFF);   // this edge is the wrap
    idle(FRAME);

    advance_to(3 * D);
    step(1'b0, 1'b1, 32'h31415926, 8'hFF, 8'hFF);   // pending only, then reset
    advance_to(4 * D + 1);
    step(1'b1, 1'b0, '0, '0, '0);
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      if (frame_done && gap == 0) gap = i;
    end
    check("rst_fd_gap", gap, 32);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) == 0, ($urandom % 6) == 0, $urandom, 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000; clocks per digit slot (1 kHz digit rate at 100 MHz), legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 value  input  32  eight hex nibbles; nibble i = value[4i+3:4i] drives digit i.
REQ-005 dp_in  input  8  decimal point request per digit, 1 = lit.
REQ-006 en_mask  input  8  digit enable per digit, 1 = digit shown.
REQ-007 load  input  1  one-cycle strobe; captures value, dp_in and en_mask.
REQ-008 Anode  output  8  digit drive, active-low, one-hot-low or all-high.
REQ-009 Cathode  output  8  {DP, g, f, e, d, c, b, a}, active-low.
REQ-010 frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-011 The tick counter shall count 0..REFRESH_DIV-1, wrap to 0, and assert internal tick for the single cycle it holds REFRESH_DIV-1.
REQ-012 The 3-bit digit index shall increment on tick and wrap 7->0.
REQ-013 frame_done shall be high for exactly the cycle in which the index transitions 7->0.
REQ-014 load shall write value/dp_in/en_mask into a pending register set; load with no tick-wrap shall not alter the display.
REQ-015 At each 7->0 wrap the active register set shall copy pending; if load coincides with the wrap, active shall take the load-cycle inputs directly.
REQ-016 Anode and Cathode shall be registered and reflect the digit index one cycle after it changes (latency 1).
REQ-017 For an enabled digit i: Anode = all-high except bit i low; Cathode[6:0] = hex_to_7seg(nibble i); Cathode[7] = ~dp_active[i].
REQ-018 For a disabled digit: Anode = 8'hFF and Cathode = 8'hFF for that slot; the index still advances.
REQ-019 Hex encoding (Cathode with DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-020 At most one Anode bit shall be low in any cycle.

Reset
REQ-021 While rst is high: tick counter = 0, index = 0, pending and active registers = 0, Anode = 8'hFF, Cathode = 8'hFF, frame_done = 0.
REQ-022 rst asserted mid-frame shall take effect on the next edge, discard any pending load, and restart the scan at digit 0 with display blank until a load has reached active.
REQ-023 load asserted in the same cycle as rst shall be ignored.

Structure
REQ-024 A shared package seg_pkg shall hold NUM_DIGITS = 8, SEG_BLANK = 8'hFF, the 16-entry hex segment table constants, and the default REFRESH_DIV.
REQ-025 Hex-to-segment decoding shall be a separate combinational sub-module hex_to_7seg (4-bit in, 7-bit active-low g..a out).
REQ-026 seg_scan shall be instantiated by the board top level that drives Anode/Cathode pins; no other logic shall drive those pins.

Verification (REFRESH_DIV = 4)
REQ-027 Reset then idle 40 cycles -> Anode = FF, Cathode = FF throughout, frame_done pulses every 32 cycles.
REQ-028 load value = 32'h76543210, en_mask = FF, dp_in = 00 -> after next wrap, Anode steps FE, FD, FB, ... 7F every 4 cycles with Cathode C0, F9, A4, B0, 99, 92, 82, F8.
REQ-029 load value = 32'hFFFFFFFF, dp_in = 8'h01, en_mask = 8'h81 -> digit 0 shows Anode FE / Cathode 0E, digit 7 shows 7F / 8E, digits 1-6 show FF / FF.
REQ-030 Two loads (A then B) within one frame -> display unchanged until wrap, then shows B only; load on the wrap cycle -> that value shown in the very next frame.
REQ-031 rst pulsed at digit 4 of an active frame -> next cycle all-blank, index 0, pending discarded, frame_done next at 32 cycles after rst release.
REQ-032 Every cycle of all scenarios -> popcount(~Anode) <= 1 and frame_done never high two consecutive cycles.
